dog_window_extrema_cmp: RTL and testbench
=========================================

// Module: dog_window_extrema_cmp
// PURPOSE
// - Per-scale extremum comparator: the producer of the per-scale big/small enables that the
//   3-input AND stage combines into the final keypoint enable.
// - Takes one raster-order DoG pixel stream and builds a 3x3 window from two line buffers.
// - Compares a reference value against that window and flags strict maximum / minimum.
// - One instance per DoG scale: middle scale uses CENTER_SELF=1, upper/lower use CENTER_SELF=0.
// PARAMETERS
// - DW          12   signed DoG pixel width, two's complement
// - IMG_W       640  pixels per line, >= 3
// - IMG_H       480  lines per frame, >= 3
// - CENTER_SELF 1    1: compare window centre vs its 8 neighbours; 0: compare iRef vs all 9
// PORTS
// - iclk         in   1            clock, single domain
// - irst_n       in   1            reset, asynchronous, active-low
// - iValid       in   1            pixel strobe; low = stall
// - iFrameStart  in   1            qualified by iValid: this pixel is (row 0, col 0)
// - iPixel       in   DW           DoG pixel, signed
// - iRef         in   DW           external centre value, signed; sampled with iValid (CENTER_SELF=0 only)
// - oValid       out  1            result strobe
// - oCenter      out  DW           window centre pixel
// - oRow         out  clog2(IMG_H) centre row
// - oCol         out  clog2(IMG_W) centre column
// - oBig_en      out  1            reference > every compared pixel
// - oSmall_en    out  1            reference < every compared pixel
// BEHAVIOUR
// - Reset: all outputs 0; row/col counters 0; pipeline valid bits 0. Line-buffer contents are
//   not cleared.
// - Counters:
//   - col increments on each iValid; wraps IMG_W-1 -> 0 and increments row.
//   - row wraps IMG_H-1 -> 0.
//   - iFrameStart&iValid forces the current pixel to (0,0); the next pixel is (0,1).
// - Window: pixel accepted at (r,c) completes the window centred at (r-1,c-1).
//   - rows: line-buffer 2 output (r-2), line-buffer 1 output (r-1), iPixel (r).
//   - cols c-2..c are held in a 3-deep shift register per row.
// - Stage 1 (on iValid):
//   - shift window and line buffers; latch iRef.
//   - interior = (r>=2 && c>=2); col wrap does not clear the window, masking handles it.
//   - s1_valid <= iValid.
// - Stage 2 (when s1_valid):
//   - signed compares, all 8 (or 9) strict.
//   - oBig_en = interior & all(ref > n); oSmall_en = interior & all(ref < n).
//   - ref = window centre (CENTER_SELF=1) or latched iRef (CENTER_SELF=0).
//   - Ties give 0 for both; both never 1 at once.
// - Output timing:
//   - oValid <= s1_valid; fixed latency 2 clocks from the completing iValid.
//   - Stalls freeze stage 1 and do not corrupt the window.
//   - oCenter/oRow/oCol/en hold between strobes.
// - Boundary cases:
//   - Border centres (row 0 or col 0, and centres never formed on row/col IMG-1) give oValid
//     with en=0.
//   - Back-to-back frames with no gap are supported.
//   - iFrameStart mid-frame restarts the counters; stale buffer data is masked by interior.
// - Reset mid-frame: the next frame must begin with iFrameStart or at a counter of 0.
//   Outputs are 0 until 2 clocks after the first post-reset completing pixel.
// STRUCTURE
// - Shared package sift_det_pkg:
//   - DOG_DW, IMG_W, IMG_H defaults
//   - clog2 helper
//   - typedef dog_pix_t (signed [DOG_DW-1:0])
// - Sub-module dog_line_buffer:
//   - IMG_W-deep, DW-wide delay line, advances on enable; instantiated twice in cascade.
//   - Inferred RAM or shift register.
// - Everything else (counters, window regs, compare tree, output regs) stays in this module.
// TESTING (IMG_W=5, IMG_H=5, DW=12)
// - All zeros, pixel (2,2)=100, CENTER_SELF=1:
//   oBig_en=1 only at oRow=2,oCol=2, 2 clocks after pixel (3,3) is accepted; oSmall_en=0 throughout.
// - Same frame with (2,2)=-100 -> oSmall_en=1 at (2,2) only; oBig_en=0.
// - (2,2)=100 and (1,1)=100 -> both enables 0 at (2,2): a tie is not an extremum.
// - Frame max 2047 at (0,2) and min -2048 at (2,0) -> no enable ever asserted (border).
// - CENTER_SELF=0, window all 49, iRef=50 aligned with pixel (3,3) -> oBig_en=1 at (2,2).
//   Repeat with iRef=49 -> 0.
// - Random iValid gaps (50% duty), then irst_n pulse mid-frame followed by iFrameStart:
//   - stalled run is bit-identical to the ungapped run;
//   - post-reset frame gives results identical to a clean frame.

Source files
------------

// File: rtl/sift_det_pkg.sv
// Shared definitions for the SIFT detector datapath.
// - DOG_DW, IMG_W, IMG_H : default DoG pixel width and image geometry
// - clog2                : counter-width helper, never returns less than 1
// - dog_pix_t            : signed DoG pixel at the default width
package sift_det_pkg;

  localparam int DOG_DW = 12;
  localparam int IMG_W  = 640;
  localparam int IMG_H  = 480;

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return (bits < 1) ? 1 : bits;
  endfunction

  typedef logic signed [DOG_DW-1:0] dog_pix_t;

endpackage

// File: rtl/dog_line_buffer.sv
// Fixed-length delay line for one image row.
// The output is the value that was written DEPTH enables earlier.
// Two of these are cascaded to supply the two rows above the incoming pixel.
// Ports:
// - clk  : clock
// - en   : advance the line by one pixel
// - din  : pixel entering the line
// - dout : pixel leaving the line (written DEPTH enables ago)
module dog_line_buffer #(
  parameter int DW    = 12,
  parameter int DEPTH = 640
) (
  input  logic          clk,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: storage arrays carry no reset; it would block RAM inference, and
  // stale contents are masked downstream by the interior flag.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/dog_window_extrema_cmp.sv
// Per-scale DoG extremum comparator.
// Builds a 3x3 window over a raster-order DoG stream and flags whether the
// reference value is a strict maximum (oBig_en) or strict minimum (oSmall_en).
// CENTER_SELF=1 compares the window centre against its 8 neighbours;
// CENTER_SELF=0 compares the latched iRef against all 9 window pixels.
// Ports:
// - iclk, irst_n : clock, asynchronous active-low reset
// - iValid       : pixel strobe (low = stall)
// - iFrameStart  : with iValid, marks the pixel at (0,0)
// - iPixel, iRef : signed DoG pixel and external reference
// - oValid       : result strobe, 2 clocks after the completing pixel
// - oCenter, oRow, oCol : centre pixel and its coordinates
// - oBig_en, oSmall_en  : strict maximum / minimum flags (0 on border centres)
module dog_window_extrema_cmp
  import sift_det_pkg::*;
#(
  parameter int DW          = DOG_DW,
  parameter int IMG_W       = sift_det_pkg::IMG_W,
  parameter int IMG_H       = sift_det_pkg::IMG_H,
  parameter bit CENTER_SELF = 1'b1
) (
  input  logic                      iclk,
  input  logic                      irst_n,
  input  logic                      iValid,
  input  logic                      iFrameStart,
  input  logic signed [DW-1:0]      iPixel,
  input  logic signed [DW-1:0]      iRef,
  output logic                      oValid,
  output logic signed [DW-1:0]      oCenter,
  output logic [clog2(IMG_H)-1:0]   oRow,
  output logic [clog2(IMG_W)-1:0]   oCol,
  output logic                      oBig_en,
  output logic                      oSmall_en
);

  localparam int RW = clog2(IMG_H);
  localparam int CW = clog2(IMG_W);

  // Position counters hold the coordinates of the next pixel to arrive.
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] pix_row;
  logic [CW-1:0] pix_col;

  assign pix_row = iFrameStart ? '0 : row_cnt;
  assign pix_col = iFrameStart ? '0 : col_cnt;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (iValid) begin
      if (pix_col == CW'(IMG_W - 1)) begin
        col_cnt <= '0;
        row_cnt <= (pix_row == RW'(IMG_H - 1)) ? '0 : pix_row + 1'b1;
      end else begin
        col_cnt <= pix_col + 1'b1;
        row_cnt <= pix_row;
      end
    end
  end

  // Line buffers: lb1 yields the pixel one row above, lb2 two rows above.
  logic [DW-1:0] lb1_q;
  logic [DW-1:0] lb2_q;

  dog_line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_lb1 (
    .clk (iclk),
    .en  (iValid),
    .din (iPixel),
    .dout(lb1_q)
  );

  dog_line_buffer #(.DW(DW), .DEPTH(IMG_W)) u_lb2 (
    .clk (iclk),
    .en  (iValid),
    .din (lb1_q),
    .dout(lb2_q)
  );

  // Window: win[row][col], row 0 = r-2, col 0 = c-2. Column wrap leaves
  // previous-row pixels in the window; the interior flag masks them.
  logic signed [DW-1:0] win [3][3];

  always_ff @(posedge iclk) begin
    if (iValid) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb2_q;
      win[1][2] <= lb1_q;
      win[2][2] <= iPixel;
    end
  end

  // Stage 1 control: the centre sits one row and one column behind the
  // accepted pixel. Coordinates of border centres wrap and are meaningless.
  logic                 s1_valid;
  logic                 s1_interior;
  logic [RW-1:0]        s1_row;
  logic [CW-1:0]        s1_col;
  logic signed [DW-1:0] ref_q;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      s1_valid    <= 1'b0;
      s1_interior <= 1'b0;
      s1_row      <= '0;
      s1_col      <= '0;
      ref_q       <= '0;
    end else begin
      s1_valid <= iValid;
      if (iValid) begin
        s1_interior <= (pix_row >= RW'(2)) && (pix_col >= CW'(2));
        s1_row      <= pix_row - 1'b1;
        s1_col      <= pix_col - 1'b1;
        ref_q       <= iRef;
      end
    end
  end

  // Stage 2 compare tree: strict signed compares, so ties clear both flags.
  logic signed [DW-1:0] ref_val;
  logic                 big_all;
  logic                 small_all;

  // NOTE: every always_comb output gets a default before any conditional
  // update; a missing default on some path would infer a latch.
  always_comb begin
    ref_val   = CENTER_SELF ? win[1][1] : ref_q;
    big_all   = 1'b1;
    small_all = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!CENTER_SELF || !(i == 1 && j == 1)) begin
          if (!(ref_val > win[i][j])) big_all   = 1'b0;
          if (!(ref_val < win[i][j])) small_all = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      oValid    <= 1'b0;
      oCenter   <= '0;
      oRow      <= '0;
      oCol      <= '0;
      oBig_en   <= 1'b0;
      oSmall_en <= 1'b0;
    end else begin
      oValid <= s1_valid;
      if (s1_valid) begin
        oCenter   <= win[1][1];
        oRow      <= s1_row;
        oCol      <= s1_col;
        oBig_en   <= s1_interior & big_all;
        oSmall_en <= s1_interior & small_all;
      end
    end
  end

endmodule

// File: tb/tb_dog_window_extrema_cmp.sv
// Bench for dog_window_extrema_cmp: two instances (CENTER_SELF=1 and 0) on a
// 5x5 image share one stimulus stream. A 2-D image model predicts every result.
module tb_dog_window_extrema_cmp;

  localparam int DW = 12;
  localparam int W  = 5;
  localparam int H  = 5;

  logic                 iclk = 1'b0;
  logic                 irst_n = 1'b0;
  logic                 iValid = 1'b0;
  logic                 iFrameStart = 1'b0;
  logic signed [DW-1:0] iPixel = '0;
  logic signed [DW-1:0] iRef = '0;

  logic                 s_valid, s_big, s_small;
  logic signed [DW-1:0] s_center;
  logic [2:0]           s_row, s_col;
  logic                 e_valid, e_big, e_small;
  logic signed [DW-1:0] e_center;
  logic [2:0]           e_row, e_col;

  dog_window_extrema_cmp #(.DW(DW), .IMG_W(W), .IMG_H(H), .CENTER_SELF(1'b1)) u_self (
    .iclk(iclk), .irst_n(irst_n), .iValid(iValid), .iFrameStart(iFrameStart),
    .iPixel(iPixel), .iRef(iRef), .oValid(s_valid), .oCenter(s_center),
    .oRow(s_row), .oCol(s_col), .oBig_en(s_big), .oSmall_en(s_small)
  );

  dog_window_extrema_cmp #(.DW(DW), .IMG_W(W), .IMG_H(H), .CENTER_SELF(1'b0)) u_ext (
    .iclk(iclk), .irst_n(irst_n), .iValid(iValid), .iFrameStart(iFrameStart),
    .iPixel(iPixel), .iRef(iRef), .oValid(e_valid), .oCenter(e_center),
    .oRow(e_row), .oCol(e_col), .oBig_en(e_big), .oSmall_en(e_small)
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int due;
    bit interior;
    int center;
    int row;
    int col;
    bit bs, ss, be, se;
  } exp_t;

  exp_t exp_q[$];
  int   img [H][W];
  int   mr = 0;
  int   mc = 0;

  task automatic model_accept(input int p, input int rf, input bit fs);
    exp_t e;
    int r, c, ctr, v;
    r = fs ? 0 : mr;
    c = fs ? 0 : mc;
    img[r][c] = p;
    e.due      = cyc + 2;
    e.interior = (r >= 2) && (c >= 2);
    e.row = r - 1;
    e.col = c - 1;
    e.center = 0;
    e.bs = 0; e.ss = 0; e.be = 0; e.se = 0;
    if (e.interior) begin
      ctr = img[r-1][c-1];
      e.center = ctr;
      e.bs = 1; e.ss = 1; e.be = 1; e.se = 1;
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          v = img[r-1+dr][c-1+dc];
          if (!(dr == 0 && dc == 0)) begin
            if (!(ctr > v)) e.bs = 0;
            if (!(ctr < v)) e.ss = 0;
          end
          if (!(rf > v)) e.be = 0;
          if (!(rf < v)) e.se = 0;
        end
      end
    end
    exp_q.push_back(e);
    if (c == W - 1) begin
      mc = 0;
      mr = (r == H - 1) ? 0 : r + 1;
    end else begin
      mc = c + 1;
      mr = r;
    end
  endtask

  // ---------------- compare process ----------------
  int s_big_hits, s_small_hits, e_big_hits, e_small_hits;
  int s_big_r, s_big_c, s_small_r, s_small_c, e_big_r, e_big_c;
  logic [19:0] rec_s[$], rec_e[$], gold_s[$], gold_e[$];

  always @(negedge iclk) begin
    exp_t e;
    if (irst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("self_valid", s_valid, 1);
        check("ext_valid", e_valid, 1);
        check("self_big", s_big, e.bs);
        check("self_small", s_small, e.ss);
        check("ext_big", e_big, e.be);
        check("ext_small", e_small, e.se);
        if (e.interior) begin
          check("self_center", s_center, e.center);
          check("self_row", s_row, e.row);
          check("self_col", s_col, e.col);
          check("ext_center", e_center, e.center);
          check("ext_row", e_row, e.row);
          check("ext_col", e_col, e.col);
          rec_s.push_back({s_center, s_row, s_col, s_big, s_small});
          rec_e.push_back({e_center, e_row, e_col, e_big, e_small});
        end
        if (s_big)   begin s_big_hits++;   s_big_r = s_row;   s_big_c = s_col;   end
        if (s_small) begin s_small_hits++; s_small_r = s_row; s_small_c = s_col; end
        if (e_big)   begin e_big_hits++;   e_big_r = e_row;   e_big_c = e_col;   end
        if (e_small) e_small_hits++;
      end else begin
        check("self_valid_idle", s_valid, 0);
        check("ext_valid_idle", e_valid, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  int frame [H][W];
  int refs  [H][W];

  task automatic drive(input int p, input int rf, input bit fs, input int gap_pct);
    bit go;
    go = 1'b0;
    while (!go) begin
      @(negedge iclk);
      if (gap_pct == 0 || int'($urandom_range(99)) >= gap_pct) go = 1'b1;
      else begin
        iValid = 1'b0;
        iFrameStart = 1'b0;
        iPixel = DW'($urandom);
        iRef = DW'($urandom);
      end
    end
    iValid = 1'b1;
    iFrameStart = fs;
    iPixel = DW'(p);
    iRef = DW'(rf);
    model_accept(p, rf, fs);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iclk);
      iValid = 1'b0;
      iFrameStart = 1'b0;
    end
  endtask

  task automatic send_frame(input bit fs, input int gap_pct, input int n_pix);
    for (int k = 0; k < n_pix; k++)
      drive(frame[k / W][k % W], refs[k / W][k % W], fs && k == 0, gap_pct);
  endtask

  task automatic fill(input int pv, input int rv);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        frame[r][c] = pv;
        refs[r][c] = rv;
      end
  endtask

  task automatic clear_stats();
    s_big_hits = 0; s_small_hits = 0; e_big_hits = 0; e_small_hits = 0;
    s_big_r = -1; s_big_c = -1; s_small_r = -1; s_small_c = -1; e_big_r = -1; e_big_c = -1;
    rec_s.delete();
    rec_e.delete();
  endtask

  task automatic compare_gold(input string tag, input int reps);
    int d;
    check({tag, "_len_self"}, rec_s.size(), reps * gold_s.size());
    check({tag, "_len_ext"}, rec_e.size(), reps * gold_e.size());
    d = 0;
    for (int i = 0; i < rec_s.size() && i < reps * gold_s.size(); i++)
      if (rec_s[i] !== gold_s[i % gold_s.size()]) d++;
    for (int i = 0; i < rec_e.size() && i < reps * gold_e.size(); i++)
      if (rec_e[i] !== gold_e[i % gold_e.size()]) d++;
    check({tag, "_diffs"}, d, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, {s_valid, e_valid}, 0);
    check({tag, "_center_s"}, s_center, 0);
    check({tag, "_center_e"}, e_center, 0);
    check({tag, "_rowcol"}, {s_row, s_col, e_row, e_col}, 0);
    check({tag, "_en"}, {s_big, s_small, e_big, e_small}, 0);
  endtask

  initial begin
    clear_stats();
    repeat (3) @(negedge iclk);
    check_outputs_zero("reset");
    irst_n = 1'b1;

    // Isolated maximum at the only fully interior-checkable spot.
    fill(0, 0); frame[2][2] = 100;
    clear_stats(); send_frame(1'b1, 0, W * H); idle(4);
    check("a_big_hits", s_big_hits, 1);
    check("a_big_row", s_big_r, 2);
    check("a_big_col", s_big_c, 2);
    check("a_small_hits", s_small_hits, 0);

    // Isolated minimum.
    fill(0, 0); frame[2][2] = -100;
    clear_stats(); send_frame(1'b1, 0, W * H); idle(4);
    check("b_small_hits", s_small_hits, 1);
    check("b_small_row", s_small_r, 2);
    check("b_small_col", s_small_c, 2);
    check("b_big_hits", s_big_hits, 0);

    // Tie with a neighbour is not an extremum.
    fill(0, 0); frame[2][2] = 100; frame[1][1] = 100;
    clear_stats(); send_frame(1'b1, 0, W * H); idle(4);
    check("c_hits", s_big_hits + s_small_hits, 0);

    // Full-scale extremes on the border never flag.
    fill(0, 0); frame[0][2] = 2047; frame[2][0] = -2048;
    clear_stats(); send_frame(1'b1, 0, W * H); idle(4);
    check("d_hits", s_big_hits + s_small_hits + e_big_hits + e_small_hits, 0);

    // External reference one above a flat window.
    fill(49, 49); refs[3][3] = 50;
    clear_stats(); send_frame(1'b1, 0, W * H); idle(4);
    check("e_big_hits", e_big_hits, 1);
    check("e_big_row", e_big_r, 2);
    check("e_big_col", e_big_c, 2);
    check("e_small_hits", e_small_hits, 0);

    // External reference equal to the window.
    fill(49, 49);
    clear_stats(); send_frame(1'b1, 0, W * H); idle(4);
    check("f_hits", e_big_hits + e_small_hits, 0);

    // Random frame: ungapped reference run.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        frame[r][c] = int'($urandom_range(0, 8)) - 4;
        refs[r][c] = int'($urandom_range(0, 8)) - 4;
      end
    clear_stats(); send_frame(1'b1, 0, W * H); idle(4);
    gold_s = rec_s;
    gold_e = rec_e;
    check("gold_len", gold_s.size(), (H - 2) * (W - 2));

    // Same frame with 50% stalls must be bit-identical.
    clear_stats(); send_frame(1'b1, 50, W * H); idle(4);
    compare_gold("gapped", 1);

    // Back-to-back frames, second relying on counter wrap only.
    clear_stats(); send_frame(1'b1, 0, W * H); send_frame(1'b0, 0, W * H); idle(4);
    compare_gold("b2b", 2);

    // Restart mid-frame with iFrameStart.
    clear_stats(); send_frame(1'b1, 0, 8); send_frame(1'b1, 0, W * H); idle(4);
    compare_gold("restart", 1);

    // Reset pulse mid-frame, then a clean frame.
    send_frame(1'b1, 50, 13);
    idle(3);
    irst_n = 1'b0;
    exp_q.delete();
    mr = 0;
    mc = 0;
    idle(2);
    check_outputs_zero("midreset");
    irst_n = 1'b1;
    clear_stats(); send_frame(1'b1, 0, W * H); idle(4);
    compare_gold("postreset", 1);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
